// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state codes, bit-period helper, IO-page register map.
package uart_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;
    localparam rx_state_t ST_BREAK  = 3'd5;

    // IO-page register offsets and RX_STATUS bit positions
    localparam int REG_RX_DATA       = 0;
    localparam int REG_RX_STATUS     = 1;
    localparam int STAT_RX_VALID     = 0;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_OVERRUN      = 2;
    localparam int STAT_FRAME_ERR    = 3;
    localparam int STAT_PARITY_ERR   = 4;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_receiver_mmio_if.sv
// Pop/clear handshake and status bundle between the receiver and the SOC IO-page decode.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_mmio_if;
    logic       pop;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic       overrun;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (output pop, clr_err,
                    input  rx_data, rx_valid, rx_full, overrun, frame_err, parity_err);
    modport slave  (input  pop, clr_err,
                    output rx_data, rx_valid, rx_full, overrun, frame_err, parity_err);
`else
    modport master (output pop, clr_err,
                    input  rx_data, rx_valid, rx_full, overrun, frame_err);
    modport slave  (input  pop, clr_err,
                    output rx_data, rx_valid, rx_full, overrun, frame_err);
`endif
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head is visible combinationally, zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/uart_receiver_mmio.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a FWFT FIFO
// with sticky overrun/frame error flags.
module uart_receiver_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  RXD,
    uart_receiver_mmio_if.slave   bus
);
    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] HALF_T = CW'(CPB/2 - 1);
    localparam logic [CW-1:0] FULL_T = CW'(CPB - 1);

    logic [1:0]    r_sync;
    rx_state_t     r_state;
    rx_state_t     w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_overrun;
    logic          r_frame_err;
    logic          w_rxs;
    logic          w_tick;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic          w_ovr_evt;
    logic          w_frm_evt;
    logic [7:0]    w_rx_data;

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_cnt == ((r_state == ST_START) ? HALF_T : FULL_T));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!w_rxs) w_next = ST_START;
            ST_START:  if (w_tick) w_next = w_rxs ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:   if (w_tick && r_bit == 3'd7) w_next = ST_PARITY;
            ST_PARITY: if (w_tick) w_next = ST_STOP;
`else
            ST_DATA:   if (w_tick && r_bit == 3'd7) w_next = ST_STOP;
`endif
            ST_STOP:   if (w_tick) w_next = w_rxs ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (w_rxs) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Counter restarts on every state entry and after each bit period
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync  <= 2'b11;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            r_sync  <= {r_sync[0], RXD};
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || w_tick) ? '0 : r_cnt + CW'(1);
            if (r_state == ST_START)
                r_bit <= '0;
            else if (r_state == ST_DATA && w_tick)
                r_bit <= r_bit + 3'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == ST_DATA && w_tick) r_shift <= {w_rxs, r_shift[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_par_evt;

    assign w_par_evt = (r_state == ST_PARITY) && w_tick && ^{r_shift, w_rxs};
    assign w_push    = (r_state == ST_STOP) && w_tick && w_rxs && !r_par_bad;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == ST_PARITY && w_tick) r_par_bad <= w_par_evt;
            if (w_par_evt)        r_parity_err <= 1'b1;
            else if (bus.clr_err) r_parity_err <= 1'b0;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign w_push = (r_state == ST_STOP) && w_tick && w_rxs;
`endif

    assign w_frm_evt = (r_state == ST_STOP) && w_tick && !w_rxs;
    assign w_ovr_evt = w_push && w_full && !bus.pop;

    // A new error event outranks a simultaneous clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_evt)        r_overrun <= 1'b1;
            else if (bus.clr_err) r_overrun <= 1'b0;
            if (w_frm_evt)        r_frame_err <= 1'b1;
            else if (bus.clr_err) r_frame_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_push  (w_push),
        .i_pop   (bus.pop),
        .i_data  (r_shift),
        .o_data  (w_rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.rx_data   = w_rx_data;
    assign bus.rx_valid  = !w_empty;
    assign bus.rx_full   = w_full;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_receiver_mmio.sv
// Bench for uart_receiver_mmio in its default 8N1 build, 16 clocks per bit.
module tb_uart_receiver_mmio;
    localparam int DEPTH = 4;
    localparam int PUSH_I = 154;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    int total = 0;
    int bad = 0;

    logic [7:0] mq[$];
    bit m_ovr = 0;
    bit m_ferr = 0;

    uart_receiver_mmio_if bus();

    uart_receiver_mmio #(
        .CLK_FREQ_HZ (16),
        .BAUD_RATE   (1),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .RXD   (rxd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (mq.size() != 0) ? mq[0] : 8'h00;
        check({tag, ".valid"}, 32'(bus.rx_valid), 32'(mq.size() != 0));
        check({tag, ".full"}, 32'(bus.rx_full), 32'(mq.size() == DEPTH));
        check({tag, ".data"}, 32'(bus.rx_data), 32'(head));
        check({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
        check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
    endtask

    // Reference: a completed good frame enters the queue unless it is full;
    // a pop coinciding with the arrival is honoured only if there is something to pop.
    task automatic model_frame(input logic [7:0] b, input bit popped);
        if (popped && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1;
    endtask

    // Drives one frame; iteration i is the cycle before rising edge i counted from the start bit.
    task automatic send(input logic [7:0] b, input logic stop_lvl, input int stop_len,
                        input int pop_at, input int clr_at, input int rst_at, input bit chk_lat);
        int last;
        last = 144 + stop_len + 16;
        for (int i = 0; i < last; i++) begin
            @(negedge clk);
            if (chk_lat && i == PUSH_I)     check("lat_before", 32'(bus.rx_valid), 32'd0);
            if (chk_lat && i == PUSH_I + 1) check("lat_after", 32'(bus.rx_valid), 32'd1);
            bus.pop     = (i == pop_at);
            bus.clr_err = (i == clr_at);
            rst         = (i == rst_at);
            if (i < 16)                 rxd = 1'b0;
            else if (i < 144)           rxd = b[3'((i - 16) / 16)];
            else if (i < 144 + stop_len) rxd = stop_lvl;
            else                        rxd = 1'b1;
        end
        @(negedge clk);
        bus.pop = 1'b0;
        bus.clr_err = 1'b0;
        rst = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        bus.pop = 1'b1;
        if (mq.size() > 0) void'(mq.pop_front());
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.clr_err = 1'b1;
        m_ovr = 0;
        m_ferr = 0;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] burst [5];
        bit pnow;

        bus.pop = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send(8'hA5, 1'b1, 16, -1, -1, -1, 1'b1);
        model_frame(8'hA5, 0);
        check_state("a5");
        pop_one();
        check_state("a5_pop");

        burst = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
        for (int k = 0; k < 5; k++) begin
            send(burst[k], 1'b1, 16, -1, -1, -1, 1'b0);
            model_frame(burst[k], 0);
            if (k == 3) check_state("fill4");
        end
        check_state("overrun");
        for (int k = 0; k < 4; k++) begin
            pop_one();
            check_state("drain");
        end
        clear_err();
        check_state("clr_ovr");

        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check_state("glitch");
        b = 8'($urandom);
        send(b, 1'b1, 16, -1, -1, -1, 1'b0);
        model_frame(b, 0);
        check_state("after_glitch");
        pop_one();

        // Clear strobe lands on the same edge as the stop-bit error: flag must stay set
        send(8'h3C, 1'b0, 40, -1, PUSH_I, -1, 1'b0);
        m_ferr = 1;
        check_state("break");
        send(8'h7E, 1'b1, 16, -1, -1, -1, 1'b0);
        model_frame(8'h7E, 0);
        check_state("after_break");
        pop_one();
        clear_err();
        check_state("clr_ferr");

        for (int k = 0; k < DEPTH; k++) begin
            b = 8'($urandom);
            send(b, 1'b1, 16, -1, -1, -1, 1'b0);
            model_frame(b, 0);
        end
        check_state("full_again");
        send(8'h99, 1'b1, 16, PUSH_I, -1, -1, 1'b0);
        model_frame(8'h99, 1);
        check_state("push_pop_full");
        for (int k = 0; k < DEPTH; k++) begin
            pop_one();
            check_state("drain2");
        end
        check(".tail_empty", 32'(bus.rx_valid), 32'd0);

        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            pnow = ($urandom_range(0, 1) == 1);
            send(b, 1'b1, 16, pnow ? PUSH_I : -1, -1, -1, 1'b0);
            model_frame(b, pnow);
            check_state("rand");
            if ($urandom_range(0, 2) == 0) begin
                pop_one();
                check_state("rand_pop");
            end
        end
        while (mq.size() > 0) pop_one();
        check_state("rand_drained");

        send(8'hFF, 1'b1, 16, -1, -1, 60, 1'b0);
        mq.delete();
        m_ovr = 0;
        m_ferr = 0;
        check_state("reset_mid");
        send(8'h12, 1'b1, 16, -1, -1, -1, 1'b0);
        model_frame(8'h12, 0);
        check_state("after_reset");
        check("after_reset.byte", 32'(bus.rx_data), 32'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
